s641_resp_misr: RTL and testbench

- Response-side signature collector for the s641 sequential benchmark. It reads the 24 primary outputs of s641 each cycle and compacts them into a 24-bit multiple-input signature register (MISR).
- It sits at the output end of the benchmark harness, the counterpart of whatever drives the 35 inputs.
- After a programmed number of valid capture cycles it compares the signature with an expected value and reports PASS/DONE.

---
 rtl/s641_resp_misr_if.sv | 26 ++
 rtl/s641_resp_misr.sv | 107 ++++++++++
 tb/tb_s641_resp_misr.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/s641_resp_misr_if.sv
// Handshake and result bundle between the s641 response harness and the MISR collector.
// The harness side drives run control and response words; the collector side returns status and signature.
interface s641_resp_misr_if #(
  parameter int WIDTH = 24
);
  logic             START;
  logic             ABORT;
  logic [WIDTH-1:0] RESP;
  logic             RESP_VALID;
  logic [WIDTH-1:0] EXP_SIG;
  logic             BUSY;
  logic             DONE;
  logic             PASS;
  logic [WIDTH-1:0] SIG;
  logic [15:0]      CNT;

  modport master (
    output START, ABORT, RESP, RESP_VALID, EXP_SIG,
    input  BUSY, DONE, PASS, SIG, CNT
  );

  modport slave (
    input  START, ABORT, RESP, RESP_VALID, EXP_SIG,
    output BUSY, DONE, PASS, SIG, CNT
  );
endinterface

// File: rtl/s641_resp_misr.sv
// Response-side signature collector for s641: compacts each valid output word into a
// Galois MISR, then after CYCLES words compares against a golden signature.
module s641_resp_misr #(
  parameter int               WIDTH  = 24,
  parameter int               CYCLES = 256,
  parameter logic [WIDTH-1:0] POLY   = WIDTH'(24'h80000D),
  parameter logic [WIDTH-1:0] SEED   = '0
) (
  input logic              CK,
  input logic              RN,
  s641_resp_misr_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CAPTURE,
    S_CHECK,
    S_DONE
  } state_t;

  localparam logic [15:0] LAST_IDX = 16'(CYCLES - 1);

  state_t           state;
  logic             run_en;
  logic [WIDTH-1:0] sig;
  logic [15:0]      cnt;
  logic             busy;
  logic             done;
  logic             pass;

  function automatic logic [WIDTH-1:0] misr_step(input logic [WIDTH-1:0] s,
                                                 input logic [WIDTH-1:0] w);
    misr_step = {s[WIDTH-2:0], 1'b0} ^ w ^ (s[WIDTH-1] ? POLY : '0);
  endfunction

  // Reset release is retimed by one flop so the FSM first moves on the second edge.
  always_ff @(posedge CK or negedge RN) begin
    if (!RN) run_en <= 1'b0;
    else     run_en <= 1'b1;
  end

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      state <= S_IDLE;
      sig   <= SEED;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      pass  <= 1'b0;
    end else if (run_en) begin
      if (bus.ABORT) begin
        state <= S_IDLE;
        sig   <= SEED;
        cnt   <= '0;
        busy  <= 1'b0;
        done  <= 1'b0;
        pass  <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (bus.START) begin
              state <= S_CAPTURE;
              sig   <= SEED;
              cnt   <= '0;
              busy  <= 1'b1;
            end
          end
          S_CAPTURE: begin
            if (bus.RESP_VALID) begin
              sig <= misr_step(sig, bus.RESP);
              cnt <= cnt + 16'd1;
              if (cnt == LAST_IDX) state <= S_CHECK;
            end
          end
          S_CHECK: begin
            pass  <= (sig == bus.EXP_SIG);
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
          S_DONE: begin
            if (bus.START) begin
              state <= S_CAPTURE;
              sig   <= SEED;
              cnt   <= '0;
              pass  <= 1'b0;
              done  <= 1'b0;
              busy  <= 1'b1;
            end
          end
          default: begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.BUSY = busy;
  assign bus.DONE = done;
  assign bus.PASS = pass;
  assign bus.SIG  = sig;
  assign bus.CNT  = cnt;

endmodule

// File: tb/tb_s641_resp_misr.sv
// Bench for s641_resp_misr: four parameterisations share one stimulus bus; each scenario
// checks the instance it targets against a polynomial-arithmetic signature model.
module tb_s641_resp_misr;

  localparam logic [23:0] POLY = 24'h80000D;

  logic        CK;
  logic        RN;
  logic        start;
  logic        abort;
  logic [23:0] resp;
  logic        resp_valid;
  logic [23:0] exp_sig;

  int n_checks = 0;
  int n_fail   = 0;

  s641_resp_misr_if #(.WIDTH(24)) i2   ();
  s641_resp_misr_if #(.WIDTH(24)) i1   ();
  s641_resp_misr_if #(.WIDTH(24)) i4   ();
  s641_resp_misr_if #(.WIDTH(24)) i256 ();

  assign i2.START = start;   assign i2.ABORT = abort;   assign i2.RESP = resp;
  assign i2.RESP_VALID = resp_valid;   assign i2.EXP_SIG = exp_sig;
  assign i1.START = start;   assign i1.ABORT = abort;   assign i1.RESP = resp;
  assign i1.RESP_VALID = resp_valid;   assign i1.EXP_SIG = exp_sig;
  assign i4.START = start;   assign i4.ABORT = abort;   assign i4.RESP = resp;
  assign i4.RESP_VALID = resp_valid;   assign i4.EXP_SIG = exp_sig;
  assign i256.START = start; assign i256.ABORT = abort; assign i256.RESP = resp;
  assign i256.RESP_VALID = resp_valid; assign i256.EXP_SIG = exp_sig;

  s641_resp_misr #(.WIDTH(24), .CYCLES(2), .POLY(POLY), .SEED(24'h000000)) u2 (
    .CK(CK), .RN(RN), .bus(i2));
  s641_resp_misr #(.WIDTH(24), .CYCLES(1), .POLY(POLY), .SEED(24'h800000)) u1 (
    .CK(CK), .RN(RN), .bus(i1));
  s641_resp_misr #(.WIDTH(24), .CYCLES(4), .POLY(POLY), .SEED(24'h000000)) u4 (
    .CK(CK), .RN(RN), .bus(i4));
  s641_resp_misr #(.WIDTH(24), .CYCLES(256), .POLY(POLY), .SEED(24'h000000)) u256 (
    .CK(CK), .RN(RN), .bus(i256));

  initial CK = 1'b0;
  always #5 CK = ~CK;

  // Signature as a GF(2) polynomial: multiply by x modulo x^24+POLY, then add the word.
  function automatic logic [23:0] sig_model(input logic [23:0] s, input logic [23:0] w);
    logic [24:0] prod;
    prod = {s, 1'b0};
    if (prod[24]) prod = prod ^ {1'b1, POLY};
    return prod[23:0] ^ w;
  endfunction

  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  task automatic reset_dut();
    RN = 1'b0; start = 1'b0; abort = 1'b0; resp = '0; resp_valid = 1'b0; exp_sig = '0;
    repeat (2) tick();
    RN = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_reset();
    reset_dut();
    n_checks++; if (i256.SIG !== 24'h0 || i256.CNT !== 16'd0) begin
      n_fail++; $display("FAIL reset_vals sig=%h cnt=%0d required 000000/0", i256.SIG, i256.CNT); end
    n_checks++; if (i256.BUSY !== 1'b0 || i256.DONE !== 1'b0 || i256.PASS !== 1'b0) begin
      n_fail++; $display("FAIL reset_flags busy=%b done=%b pass=%b required 0/0/0",
                         i256.BUSY, i256.DONE, i256.PASS); end
    n_checks++; if (i1.SIG !== 24'h800000) begin
      n_fail++; $display("FAIL reset_seed sig=%h required 800000", i1.SIG); end
    start = 1'b1; tick(); start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      resp = 24'($urandom); resp_valid = 1'b1; tick();
    end
    resp_valid = 1'b0;
    n_checks++; if (i256.CNT !== 16'd5 || i256.BUSY !== 1'b1) begin
      n_fail++; $display("FAIL pre_reset_cnt cnt=%0d busy=%b required 5/1", i256.CNT, i256.BUSY); end
    #2 RN = 1'b0;
    #1;
    n_checks++; if (i256.SIG !== 24'h0 || i256.CNT !== 16'd0 || i256.BUSY !== 1'b0 || i256.DONE !== 1'b0) begin
      n_fail++; $display("FAIL async_reset sig=%h cnt=%0d busy=%b done=%b required 000000/0/0/0",
                         i256.SIG, i256.CNT, i256.BUSY, i256.DONE); end
    tick();
    RN = 1'b1; start = 1'b1;
    tick();
    n_checks++; if (i256.BUSY !== 1'b0) begin
      n_fail++; $display("FAIL release_edge1 busy=%b required 0", i256.BUSY); end
    tick();
    n_checks++; if (i256.BUSY !== 1'b1) begin
      n_fail++; $display("FAIL release_edge2 busy=%b required 1", i256.BUSY); end
    start = 1'b0; abort = 1'b1; tick(); abort = 1'b0;
  endtask

  task automatic test_two_words();
    reset_dut();
    exp_sig = 24'h000002;
    start = 1'b1; tick(); start = 1'b0;
    resp = 24'h000001; resp_valid = 1'b1; tick();
    n_checks++; if (i2.SIG !== 24'h000001 || i2.CNT !== 16'd1) begin
      n_fail++; $display("FAIL two_w1 sig=%h cnt=%0d required 000001/1", i2.SIG, i2.CNT); end
    resp = 24'h000000; tick();
    resp_valid = 1'b0; resp = 24'($urandom);
    n_checks++; if (i2.SIG !== 24'h000002 || i2.CNT !== 16'd2 || i2.BUSY !== 1'b1 || i2.DONE !== 1'b0) begin
      n_fail++; $display("FAIL two_check sig=%h cnt=%0d busy=%b done=%b required 000002/2/1/0",
                         i2.SIG, i2.CNT, i2.BUSY, i2.DONE); end
    tick();
    n_checks++; if (i2.DONE !== 1'b1 || i2.PASS !== 1'b1 || i2.BUSY !== 1'b0 || i2.SIG !== 24'h000002) begin
      n_fail++; $display("FAIL two_done done=%b pass=%b busy=%b sig=%h required 1/1/0/000002",
                         i2.DONE, i2.PASS, i2.BUSY, i2.SIG); end
  endtask

  task automatic test_feedback();
    reset_dut();
    exp_sig = 24'h80000C;
    start = 1'b1; tick(); start = 1'b0;
    resp = 24'h000000; resp_valid = 1'b1; tick(); resp_valid = 1'b0;
    n_checks++; if (i1.SIG !== 24'h80000D || i1.SIG !== sig_model(24'h800000, 24'h0) || i1.BUSY !== 1'b1) begin
      n_fail++; $display("FAIL feedback sig=%h busy=%b required 80000d/1", i1.SIG, i1.BUSY); end
    tick();
    n_checks++; if (i1.DONE !== 1'b1 || i1.PASS !== 1'b0 || i1.CNT !== 16'd1) begin
      n_fail++; $display("FAIL feedback_done done=%b pass=%b cnt=%0d required 1/0/1",
                         i1.DONE, i1.PASS, i1.CNT); end
  endtask

  task automatic test_gaps();
    logic [6:0]  pat;
    logic [23:0] m;
    int          cnt_exp [7] = '{1, 1, 1, 2, 3, 3, 4};
    reset_dut();
    pat = 7'b1011001;
    m = 24'h0;
    start = 1'b1; tick(); start = 1'b0;
    for (int k = 0; k < 7; k++) begin
      resp = 24'($urandom); resp_valid = pat[k];
      tick();
      if (pat[k]) m = sig_model(m, resp);
      n_checks++; if (i4.CNT !== 16'(cnt_exp[k]) || i4.BUSY !== 1'b1) begin
        n_fail++; $display("FAIL gaps_cnt[%0d] cnt=%0d busy=%b required %0d/1",
                           k, i4.CNT, i4.BUSY, cnt_exp[k]); end
    end
    resp_valid = 1'b0;
    exp_sig = m;
    n_checks++; if (i4.SIG !== m || i4.DONE !== 1'b0) begin
      n_fail++; $display("FAIL gaps_sig sig=%h done=%b required %h/0", i4.SIG, i4.DONE, m); end
    tick();
    n_checks++; if (i4.DONE !== 1'b1 || i4.PASS !== 1'b1 || i4.BUSY !== 1'b0) begin
      n_fail++; $display("FAIL gaps_done done=%b pass=%b busy=%b required 1/1/0",
                         i4.DONE, i4.PASS, i4.BUSY); end
  endtask

  task automatic test_abort();
    logic [23:0] w;
    reset_dut();
    start = 1'b1; tick(); start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      resp = 24'($urandom); resp_valid = 1'b1; tick();
    end
    n_checks++; if (i256.CNT !== 16'd3) begin
      n_fail++; $display("FAIL abort_pre cnt=%0d required 3", i256.CNT); end
    abort = 1'b1; start = 1'b1; resp = 24'($urandom); tick();
    abort = 1'b0; start = 1'b0; resp_valid = 1'b0;
    n_checks++; if (i256.CNT !== 16'd0 || i256.SIG !== 24'h0 || i256.BUSY !== 1'b0 ||
                    i256.DONE !== 1'b0 || i256.PASS !== 1'b0) begin
      n_fail++; $display("FAIL abort cnt=%0d sig=%h busy=%b done=%b pass=%b required 0/000000/0/0/0",
                         i256.CNT, i256.SIG, i256.BUSY, i256.DONE, i256.PASS); end
    start = 1'b1; tick(); start = 1'b0;
    n_checks++; if (i256.BUSY !== 1'b1 || i256.CNT !== 16'd0) begin
      n_fail++; $display("FAIL abort_restart busy=%b cnt=%0d required 1/0", i256.BUSY, i256.CNT); end
    w = 24'($urandom); resp = w; resp_valid = 1'b1; tick(); resp_valid = 1'b0;
    n_checks++; if (i256.CNT !== 16'd1 || i256.SIG !== sig_model(24'h0, w)) begin
      n_fail++; $display("FAIL abort_fresh cnt=%0d sig=%h required 1/%h",
                         i256.CNT, i256.SIG, sig_model(24'h0, w)); end
  endtask

  task automatic test_restart();
    logic [23:0] m;
    reset_dut();
    m = 24'h0;
    start = 1'b1; tick(); start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      resp = 24'($urandom); resp_valid = 1'b1; tick();
      m = sig_model(m, resp);
    end
    resp_valid = 1'b0; exp_sig = m;
    tick();
    n_checks++; if (i2.DONE !== 1'b1 || i2.PASS !== 1'b1) begin
      n_fail++; $display("FAIL restart_pre done=%b pass=%b required 1/1", i2.DONE, i2.PASS); end
    start = 1'b1; tick(); start = 1'b0;
    n_checks++; if (i2.PASS !== 1'b0 || i2.DONE !== 1'b0 || i2.BUSY !== 1'b1 ||
                    i2.SIG !== 24'h0 || i2.CNT !== 16'd0) begin
      n_fail++; $display("FAIL restart pass=%b done=%b busy=%b sig=%h cnt=%0d required 0/0/1/000000/0",
                         i2.PASS, i2.DONE, i2.BUSY, i2.SIG, i2.CNT); end
    n_checks++; if (i1.SIG !== 24'h800000 || i1.BUSY !== 1'b1) begin
      n_fail++; $display("FAIL restart_seed sig=%h busy=%b required 800000/1", i1.SIG, i1.BUSY); end
  endtask

  task automatic test_random_run(input bit mismatch);
    logic [23:0] m;
    logic [23:0] flip;
    int          acc;
    int          guard;
    reset_dut();
    m = 24'h0; acc = 0; guard = 0;
    start = 1'b1; resp_valid = 1'b1; resp = 24'($urandom); tick();
    n_checks++; if (i256.CNT !== 16'd0 || i256.SIG !== 24'h0 || i256.BUSY !== 1'b1) begin
      n_fail++; $display("FAIL start_valid cnt=%0d sig=%h busy=%b required 0/000000/1",
                         i256.CNT, i256.SIG, i256.BUSY); end
    while (acc < 256 && guard < 3000) begin
      resp_valid = 1'($urandom_range(0, 1));
      resp = 24'($urandom);
      start = ($urandom_range(0, 7) == 0);
      tick();
      guard++;
      if (resp_valid) begin
        m = sig_model(m, resp);
        acc++;
      end
      n_checks++; if (i256.CNT !== 16'(acc)) begin
        n_fail++; $display("FAIL rand_cnt cnt=%0d required %0d", i256.CNT, acc); end
    end
    if (acc < 256) begin
      n_checks++; n_fail++;
      $display("FAIL rand_timeout accepted=%0d required 256", acc);
    end
    start = 1'b0; resp_valid = 1'b0;
    flip = mismatch ? (24'h1 << $urandom_range(0, 23)) : 24'h0;
    exp_sig = m ^ flip;
    n_checks++; if (i256.SIG !== m || i256.BUSY !== 1'b1 || i256.DONE !== 1'b0) begin
      n_fail++; $display("FAIL rand_check sig=%h busy=%b done=%b required %h/1/0",
                         i256.SIG, i256.BUSY, i256.DONE, m); end
    tick();
    n_checks++; if (i256.DONE !== 1'b1 || i256.PASS !== !mismatch || i256.CNT !== 16'd256) begin
      n_fail++; $display("FAIL rand_done done=%b pass=%b cnt=%0d required 1/%b/256",
                         i256.DONE, i256.PASS, i256.CNT, !mismatch); end
    for (int k = 0; k < 3; k++) begin
      resp_valid = 1'b1; resp = 24'($urandom); tick();
    end
    resp_valid = 1'b0;
    n_checks++; if (i256.SIG !== m || i256.CNT !== 16'd256 || i256.DONE !== 1'b1 || i256.PASS !== !mismatch) begin
      n_fail++; $display("FAIL rand_hold sig=%h cnt=%0d done=%b pass=%b required %h/256/1/%b",
                         i256.SIG, i256.CNT, i256.DONE, i256.PASS, m, !mismatch); end
  endtask

  initial begin
    test_reset();
    test_two_words();
    test_feedback();
    test_gaps();
    test_abort();
    test_restart();
    test_random_run(1'b0);
    test_random_run(1'b1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
